// File: rtl/cpu_core_mc.sv
// Multi-cycle core: FETCH/DECODE/EXEC/MEM/WB/HALT FSM with valid/ready imem and dmem handshakes.
// Define CPU_CORE_MC_PERF_EN to add the perf_cycles / perf_retired counters.
module cpu_core_mc #(
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    REG_ADDR_WIDTH = 5,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC       = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_ready,
  input  logic [31:0]           imem_data,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [ADDR_WIDTH-1:0] dmem_addr,
  output logic [DATA_WIDTH-1:0] dmem_wdata,
  input  logic                  dmem_ready,
  input  logic [DATA_WIDTH-1:0] dmem_rdata,
  output logic                  halted,
  output logic [ADDR_WIDTH-1:0] debug_pc,
  output logic [31:0]           debug_instr
`ifdef CPU_CORE_MC_PERF_EN
  ,
  output logic [31:0]           perf_cycles,
  output logic [31:0]           perf_retired
`endif
);

  localparam int                    NUM_REGS = 2 ** REG_ADDR_WIDTH;
  localparam int                    SHAMT_W  = $clog2(DATA_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] PC_STEP  = ADDR_WIDTH'(4);

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_e;

  typedef enum logic [3:0] {
    OP_ADD = 4'h0, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR,
    OP_LD, OP_ST, OP_BEQ, OP_JMP, OP_HALT = 4'hF
  } opcode_e;

  state_e                    state_q, state_d;
  logic [ADDR_WIDTH-1:0]     pc_q, pc_d;
  logic [31:0]               instr_q, instr_d;
  logic [DATA_WIDTH-1:0]     op_a_q, op_a_d, op_b_q, op_b_d;
  logic [DATA_WIDTH-1:0]     wb_data_q, wb_data_d;
  logic                      imem_req_q, imem_req_d;
  logic                      dmem_req_q, dmem_req_d;
  logic                      dmem_we_q, dmem_we_d;
  logic [ADDR_WIDTH-1:0]     dmem_addr_q, dmem_addr_d;
  logic [DATA_WIDTH-1:0]     dmem_wdata_q, dmem_wdata_d;
  logic [DATA_WIDTH-1:0]     regs_q [NUM_REGS];
  logic                      rf_we;

  logic [3:0]                op;
  logic [REG_ADDR_WIDTH-1:0] rd_idx, rs1_idx, rs2_idx;
  logic [DATA_WIDTH-1:0]     imm_ext, alu_res;
  logic [ADDR_WIDTH-1:0]     br_off;

  assign op      = instr_q[31:28];
  assign rd_idx  = instr_q[23 +: REG_ADDR_WIDTH];
  assign rs1_idx = instr_q[18 +: REG_ADDR_WIDTH];
  assign rs2_idx = instr_q[13 +: REG_ADDR_WIDTH];
  assign imm_ext = DATA_WIDTH'($signed(instr_q[12:0]));
  assign br_off  = ADDR_WIDTH'($signed({instr_q[12:0], 2'b00}));

  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:  alu_res = op_a_q + op_b_q;
      OP_SUB:  alu_res = op_a_q - op_b_q;
      OP_AND:  alu_res = op_a_q & op_b_q;
      OP_OR:   alu_res = op_a_q | op_b_q;
      OP_XOR:  alu_res = op_a_q ^ op_b_q;
      OP_SHL:  alu_res = op_a_q << op_b_q[SHAMT_W-1:0];
      OP_SHR:  alu_res = op_a_q >> op_b_q[SHAMT_W-1:0];
      default: alu_res = '0;
    endcase
  end

  // NOTE: every _d gets its hold value first so no path through this block can infer a latch.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    wb_data_d    = wb_data_q;
    dmem_we_d    = dmem_we_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_wdata_d = dmem_wdata_q;
    rf_we        = 1'b0;

    case (state_q)
      S_FETCH: begin
        if (imem_req_q && imem_ready) begin
          instr_d = imem_data;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        op_a_d  = regs_q[rs1_idx];
        op_b_d  = regs_q[rs2_idx];
        state_d = S_EXEC;
      end
      S_EXEC: begin
        case (op)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR: begin
            wb_data_d = alu_res;
            state_d   = S_WB;
          end
          OP_LD, OP_ST: begin
            dmem_addr_d  = ADDR_WIDTH'(op_a_q + imm_ext);
            dmem_wdata_d = op_b_q;
            dmem_we_d    = (op == OP_ST);
            state_d      = S_MEM;
          end
          OP_BEQ: begin
            pc_d    = (op_a_q == op_b_q) ? pc_q + br_off : pc_q + PC_STEP;
            state_d = S_FETCH;
          end
          OP_JMP: begin
            pc_d    = pc_q + br_off;
            state_d = S_FETCH;
          end
          OP_HALT: state_d = S_HALT;
          default: begin
            pc_d    = pc_q + PC_STEP;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEM: begin
        if (dmem_req_q && dmem_ready) begin
          if (dmem_we_q) begin
            pc_d    = pc_q + PC_STEP;
            state_d = S_FETCH;
          end else begin
            wb_data_d = dmem_rdata;
            state_d   = S_WB;
          end
        end
      end
      S_WB: begin
        rf_we   = 1'b1;
        pc_d    = pc_q + PC_STEP;
        state_d = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase

    // Requests are registered so they are glitch-free and rise one edge after reset release.
    imem_req_d = (state_d == S_FETCH);
    dmem_req_d = (state_d == S_MEM);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_FETCH;
      pc_q         <= RESET_PC;
      instr_q      <= '0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      wb_data_q    <= '0;
      imem_req_q   <= 1'b0;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      wb_data_q    <= wb_data_d;
      imem_req_q   <= imem_req_d;
      dmem_req_q   <= dmem_req_d;
      dmem_we_q    <= dmem_we_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_wdata_q <= dmem_wdata_d;
    end
  end

  // NOTE: the register file is reset because all registers must read 0 after reset, so it is flops, not RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (rf_we && (rd_idx != '0)) begin
      regs_q[rd_idx] <= wb_data_q;
    end
  end

`ifdef CPU_CORE_MC_PERF_EN
  logic [31:0] perf_cycles_q, perf_retired_q;
  logic        retire;

  assign retire = (state_d == S_FETCH) &&
                  ((state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WB));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cycles_q  <= '0;
      perf_retired_q <= '0;
    end else begin
      if (state_q != S_HALT) perf_cycles_q  <= perf_cycles_q + 32'd1;
      if (retire)            perf_retired_q <= perf_retired_q + 32'd1;
    end
  end

  assign perf_cycles  = perf_cycles_q;
  assign perf_retired = perf_retired_q;
`endif

  assign imem_req    = imem_req_q;
  assign imem_addr   = pc_q;
  assign dmem_req    = dmem_req_q;
  assign dmem_we     = dmem_we_q;
  assign dmem_addr   = dmem_addr_q;
  assign dmem_wdata  = dmem_wdata_q;
  assign halted      = (state_q == S_HALT);
  assign debug_pc    = pc_q;
  assign debug_instr = instr_q;

endmodule
